// File: rtl/nios2_proc_debug_pkg.sv
// Shared types and jdo field positions for the on-chip debug memory engine.
package nios2_proc_debug_pkg;

   localparam int OCI_DATA_W    = 32;

   localparam int JDO_ADDR_LSB  = 3;
   localparam int JDO_RDLOAD    = 17;
   localparam int JDO_WDATA_LSB = 3;
   localparam int JDO_RDNEXT    = 35;
   localparam int JDO_WPROT     = 36;

   typedef enum logic [2:0] {
      S_IDLE,
      S_J_RD,
      S_J_RDW,
      S_J_WR,
      S_C_RD,
      S_C_RDW
   } ocimem_state_t;

endpackage

// File: rtl/nios2_proc_debug_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM with a registered (1-cycle) read port.
module nios2_proc_debug_ocimem_ram
   import nios2_proc_debug_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int INIT_ZERO = 1
) (
   input  logic                  clk,
   input  logic [ADDR_W-1:0]     address,
   input  logic                  we,
   input  logic [OCI_DATA_W-1:0] d,
   output logic [OCI_DATA_W-1:0] q
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [OCI_DATA_W-1:0] r_mem [DEPTH];
   logic [OCI_DATA_W-1:0] r_q;

   // Storage has no reset; INIT_ZERO only describes how simulation starts it.
   logic w_unused_cfg;
   assign w_unused_cfg = (INIT_ZERO != 0);

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[address] <= d;
      end
      r_q <= r_mem[address];
   end

   assign q = r_q;

endmodule

// File: rtl/nios2_proc_debug_ocimem_engine.sv
// Debug-RAM engine: JTAG load/read-next/write-next commands plus a CPU Avalon-MM port.
// Optional CPU write protection is built when OCIMEM_CPU_WPROT_EN is defined.
module nios2_proc_debug_ocimem_engine
   import nios2_proc_debug_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int INIT_ZERO = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [37:0]           jdo,
   input  logic                  take_action_ocimem_a,
   input  logic                  take_no_action_ocimem_a,
   input  logic                  take_action_ocimem_b,
   output logic [OCI_DATA_W-1:0] MonDReg,
   output logic                  monitor_ready,
   output logic                  monitor_error,
   input  logic [ADDR_W-1:0]     avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [OCI_DATA_W-1:0] avs_writedata,
   output logic [OCI_DATA_W-1:0] avs_readdata,
   output logic                  avs_waitrequest
);

   ocimem_state_t         r_state;
   ocimem_state_t         w_next_state;
   logic [ADDR_W-1:0]     r_mon_areg;
   logic [OCI_DATA_W-1:0] r_mon_dreg;
   logic                  r_mon_ready;
   logic                  r_mon_error;
   logic [OCI_DATA_W-1:0] r_wdata;
   logic [OCI_DATA_W-1:0] r_avs_rdata;

   logic [ADDR_W-1:0]     w_jdo_addr;
   logic [ADDR_W-1:0]     w_ram_addr;
   logic                  w_ram_we;
   logic [OCI_DATA_W-1:0] w_ram_d;
   logic [OCI_DATA_W-1:0] w_ram_q;
   logic                  w_avs_wait;
   logic                  w_jtag_any;
   logic                  w_rdnext;
   logic                  w_cpu_wr_ok;
   logic                  w_unused_jdo;

   assign w_jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
   assign w_rdnext     = take_no_action_ocimem_a & jdo[JDO_RDNEXT];
   assign w_jtag_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign w_unused_jdo = ^jdo;

`ifdef OCIMEM_CPU_WPROT_EN
   logic r_wprot;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wprot <= 1'b0;
      end else if (r_state == S_IDLE && take_action_ocimem_a) begin
         r_wprot <= jdo[JDO_WPROT];
      end
   end

   assign w_cpu_wr_ok = ~r_wprot;
`else
   assign w_cpu_wr_ok = 1'b1;
`endif

   // In IDLE the RAM already sees avs_address, so a CPU read is launched on the
   // IDLE->C_RD edge and q is ready to be registered at the end of C_RD; that
   // keeps avs_readdata valid in the C_RDW cycle where waitrequest drops.
   always_comb begin
      w_next_state = r_state;
      w_ram_addr   = avs_address;
      w_ram_we     = 1'b0;
      w_ram_d      = avs_writedata;
      w_avs_wait   = avs_read | avs_write;

      unique case (r_state)
         S_IDLE: begin
            if (take_action_ocimem_a) begin
               w_next_state = jdo[JDO_RDLOAD] ? S_J_RD : S_IDLE;
            end else if (take_action_ocimem_b) begin
               w_next_state = S_J_WR;
            end else if (take_no_action_ocimem_a) begin
               if (w_rdnext) begin
                  w_next_state = S_J_RD;
               end
            end else if (avs_read) begin
               w_next_state = S_C_RD;
            end else if (avs_write) begin
               w_ram_we   = w_cpu_wr_ok;
               w_avs_wait = 1'b0;
            end
         end
         S_J_RD: begin
            w_ram_addr   = r_mon_areg;
            w_next_state = S_J_RDW;
         end
         S_J_RDW: begin
            w_ram_addr   = r_mon_areg;
            w_next_state = S_IDLE;
         end
         S_J_WR: begin
            w_ram_addr   = r_mon_areg;
            w_ram_we     = 1'b1;
            w_ram_d      = r_wdata;
            w_next_state = S_IDLE;
         end
         S_C_RD: begin
            w_next_state = S_C_RDW;
         end
         S_C_RDW: begin
            w_avs_wait   = 1'b0;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      if (reset) begin
         w_ram_we     = 1'b0;
         w_avs_wait   = 1'b1;
         w_next_state = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_mon_areg  <= '0;
         r_mon_dreg  <= '0;
         r_mon_ready <= 1'b0;
         r_mon_error <= 1'b0;
         r_avs_rdata <= '0;
      end else begin
         r_state <= w_next_state;

         if (r_state == S_IDLE) begin
            if (take_action_ocimem_a) begin
               r_mon_areg  <= w_jdo_addr;
               r_mon_ready <= 1'b0;
               r_mon_error <= 1'b0;
            end else if (!take_action_ocimem_b && w_rdnext) begin
               r_mon_ready <= 1'b0;
            end
         end else if (w_jtag_any) begin
            r_mon_error <= 1'b1;
         end

         case (r_state)
            S_J_RDW: begin
               r_mon_dreg  <= w_ram_q;
               r_mon_ready <= 1'b1;
               r_mon_areg  <= r_mon_areg + 1'b1;
            end
            S_J_WR: begin
               r_mon_areg <= r_mon_areg + 1'b1;
            end
            S_C_RD: begin
               r_avs_rdata <= w_ram_q;
            end
            default: begin
            end
         endcase
      end
   end

   // Write-data holding register needs no reset: it is only consumed in J_WR.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && take_action_ocimem_b && !take_action_ocimem_a) begin
         r_wdata <= jdo[JDO_WDATA_LSB +: OCI_DATA_W];
      end
   end

   nios2_proc_debug_ocimem_ram #(
      .ADDR_W    (ADDR_W),
      .INIT_ZERO (INIT_ZERO)
   ) u_ram (
      .clk     (clk),
      .address (w_ram_addr),
      .we      (w_ram_we),
      .d       (w_ram_d),
      .q       (w_ram_q)
   );

   assign MonDReg         = r_mon_dreg;
   assign monitor_ready   = r_mon_ready;
   assign monitor_error   = r_mon_error;
   assign avs_readdata    = r_avs_rdata;
   assign avs_waitrequest = w_avs_wait;

endmodule
